// File: rtl/equation_checker_if.sv
// Player-facing bus of the arithmetic quiz block: start/answer inputs and
// displayed equation plus result outputs.
interface equation_checker_if;
  logic       Start;
  logic       Go;
  logic [6:0] DataIn;
  logic [3:0] OpA;
  logic [3:0] OpB;
  logic       OpSel;
  logic [6:0] Expected;
  logic       Correct;
  logic       Wrong;
  logic [1:0] Attempts;
  logic       Busy;

  modport slave (
    input  Start, Go, DataIn,
    output OpA, OpB, OpSel, Expected, Correct, Wrong, Attempts, Busy
  );

  modport master (
    output Start, Go, DataIn,
    input  OpA, OpB, OpSel, Expected, Correct, Wrong, Attempts, Busy
  );
endinterface

// File: rtl/equation_checker.sv
// Generates a pseudo-random add/subtract equation, accepts player answers
// on Go rising edges and reports completion after a match or MAX_TRIES misses.
module equation_checker #(
  parameter int unsigned MAX_TRIES = 3,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic               Clock,
  input  logic               Reset,
  equation_checker_if.slave  bus
);

  localparam int unsigned OPW   = 4;
  localparam int unsigned RESW  = 7;
  localparam int unsigned LFSRW = 8;
  localparam int unsigned ATTW  = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GEN     = 3'd1,
    WAIT_GO = 3'd2,
    CHECK   = 3'd3,
    RESULT  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               start_q, go_q;
  logic [LFSRW-1:0]   lfsr_q;
  logic [OPW-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic               opsel_q, opsel_d;
  logic [RESW-1:0]    expected_q, expected_d;
  logic [RESW-1:0]    answer_q, answer_d;
  logic               wrong_q, wrong_d;
  logic [ATTW-1:0]    attempts_q, attempts_d;
  logic               correct_q, correct_d;
  logic               busy_q, busy_d;

  logic               start_rise, go_rise;
  logic               lfsr_fb;
  logic [OPW-1:0]     gen_hi, gen_lo;
  logic [RESW-1:0]    gen_result;
  logic [ATTW-1:0]    att_inc;

  assign start_rise = bus.Start & ~start_q;
  assign go_rise    = bus.Go & ~go_q;
  assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign att_inc    = (attempts_q == ATTW'(3)) ? attempts_q : attempts_q + ATTW'(1);

  // Operand ordering keeps subtraction results non-negative.
  always_comb begin
    gen_hi = lfsr_q[7:4];
    gen_lo = lfsr_q[3:0];
    if (lfsr_q[0] && (lfsr_q[7:4] < lfsr_q[3:0])) begin
      gen_hi = lfsr_q[3:0];
      gen_lo = lfsr_q[7:4];
    end
    if (lfsr_q[0]) begin
      gen_result = RESW'(gen_hi) - RESW'(gen_lo);
    end else begin
      gen_result = RESW'(gen_hi) + RESW'(gen_lo);
    end
  end

  always_comb begin
    state_d    = state_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    opsel_d    = opsel_q;
    expected_d = expected_q;
    answer_d   = answer_q;
    wrong_d    = wrong_q;
    attempts_d = attempts_q;

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d    = GEN;
          wrong_d    = 1'b0;
          attempts_d = '0;
        end
      end
      GEN: begin
        if (!bus.Start) begin
          state_d = IDLE;
        end else begin
          opsel_d    = lfsr_q[0];
          opa_d      = gen_hi;
          opb_d      = gen_lo;
          expected_d = gen_result;
          state_d    = WAIT_GO;
        end
      end
      WAIT_GO: begin
        if (!bus.Start) begin
          state_d = IDLE;
        end else if (go_rise) begin
          answer_d = bus.DataIn;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (!bus.Start) begin
          state_d = IDLE;
        end else if (answer_q == expected_q) begin
          state_d = RESULT;
        end else begin
          wrong_d    = 1'b1;
          attempts_d = att_inc;
          state_d    = (att_inc == ATTW'(MAX_TRIES)) ? RESULT : WAIT_GO;
        end
      end
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status flags are registered from the next state so they align with state_q.
    correct_d = (state_d == RESULT);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      go_q       <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      opa_q      <= '0;
      opb_q      <= '0;
      opsel_q    <= 1'b0;
      expected_q <= '0;
      answer_q   <= '0;
      wrong_q    <= 1'b0;
      attempts_q <= '0;
      correct_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= bus.Start;
      go_q       <= bus.Go;
      lfsr_q     <= {lfsr_q[6:0], lfsr_fb};
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      opsel_q    <= opsel_d;
      expected_q <= expected_d;
      answer_q   <= answer_d;
      wrong_q    <= wrong_d;
      attempts_q <= attempts_d;
      correct_q  <= correct_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.OpA      = opa_q;
  assign bus.OpB      = opb_q;
  assign bus.OpSel    = opsel_q;
  assign bus.Expected = expected_q;
  assign bus.Correct  = correct_q;
  assign bus.Wrong    = wrong_q;
  assign bus.Attempts = attempts_q;
  assign bus.Busy     = busy_q;

endmodule

// File: tb/tb_equation_checker.sv
// Directed and randomized checks of equation_checker against an arithmetic
// reference model of the equation generator and attempt bookkeeping.
module tb_equation_checker;

  localparam int unsigned MAX_TRIES = 3;
  localparam logic [7:0]  SEED      = 8'hA5;

  logic Clock;
  logic Reset;
  int   vectors;
  int   miscompares;
  int   cyc;

  int   m_a, m_b, m_sel, m_exp, m_att, m_wrong;

  equation_checker_if bus ();

  equation_checker #(
    .MAX_TRIES (MAX_TRIES),
    .LFSR_SEED (SEED)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Cycles since reset release; the LFSR value is derived from this count.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] v;
    v = SEED;
    for (int i = 0; i < n; i++) v = {v[6:0], ^(v & 8'hB8)};
    return v;
  endfunction

  task automatic model_eq(input logic [7:0] l);
    int a, b, t;
    a = int'(l) / 16;
    b = int'(l) % 16;
    m_sel = int'(l) % 2;
    if (m_sel == 1 && a < b) begin
      t = a; a = b; b = t;
    end
    m_a = a;
    m_b = b;
    m_exp = (m_sel == 1) ? a - b : a + b;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_opa"}, int'(bus.OpA), 0);
    check({tag, "_opb"}, int'(bus.OpB), 0);
    check({tag, "_opsel"}, int'(bus.OpSel), 0);
    check({tag, "_exp"}, int'(bus.Expected), 0);
    check({tag, "_att"}, int'(bus.Attempts), 0);
    check({tag, "_correct"}, int'(bus.Correct), 0);
    check({tag, "_wrong"}, int'(bus.Wrong), 0);
    check({tag, "_busy"}, int'(bus.Busy), 0);
  endtask

  // Start rises (or is already high) and is sampled at the next edge.
  task automatic raise_start();
    bus.Start = 1'b1;
    tick();
    check("gen_busy", int'(bus.Busy), 1);
    model_eq(lfsr_after(cyc));
    m_att = 0;
    m_wrong = 0;
    tick();
    check("opa", int'(bus.OpA), m_a);
    check("opb", int'(bus.OpB), m_b);
    check("opsel", int'(bus.OpSel), m_sel);
    check("expected", int'(bus.Expected), m_exp);
    check("start_wrong", int'(bus.Wrong), 0);
    check("start_att", int'(bus.Attempts), 0);
    check("wait_busy", int'(bus.Busy), 1);
    check("wait_correct", int'(bus.Correct), 0);
  endtask

  task automatic new_eq(input int gap);
    bus.Start = 1'b0;
    repeat (gap + 1) tick();
    raise_start();
  endtask

  task automatic submit(input int ans, output bit done);
    bit hit;
    bus.DataIn = 7'(ans);
    bus.Go = 1'b1;
    tick();
    check("chk_busy", int'(bus.Busy), 1);
    check("chk_no_correct", int'(bus.Correct), 0);
    bus.Go = 1'b0;
    tick();
    hit = (ans == m_exp);
    if (!hit) begin
      m_wrong = 1;
      if (m_att < 3) m_att++;
    end
    done = hit || (m_att == int'(MAX_TRIES));
    check("correct_pulse", int'(bus.Correct), done ? 1 : 0);
    check("wrong_flag", int'(bus.Wrong), m_wrong);
    check("attempts", int'(bus.Attempts), m_att);
    if (done) begin
      tick();
      check("pulse_end", int'(bus.Correct), 0);
      check("done_idle", int'(bus.Busy), 0);
      check("hold_wrong", int'(bus.Wrong), m_wrong);
      check("hold_att", int'(bus.Attempts), m_att);
    end
  endtask

  function automatic int wrong_answer(input int exp);
    int a;
    a = exp;
    while (a == exp) a = int'($urandom_range(0, 127));
    return a;
  endfunction

  initial begin
    bit done;
    vectors = 0;
    miscompares = 0;
    Reset = 1'b1;
    bus.Start = 1'b0;
    bus.Go = 1'b0;
    bus.DataIn = '0;
    repeat (3) tick();
    check_all_zero("rst");
    Reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_busy", int'(bus.Busy), 0);
      check("idle_correct", int'(bus.Correct), 0);
    end
    check_all_zero("idle");

    // Correct answer on the first try; Start then held high must not retrigger.
    raise_start();
    submit(m_exp, done);
    repeat (5) begin
      tick();
      check("no_retrigger", int'(bus.Busy), 0);
    end

    // One miss followed by the right answer.
    new_eq(2);
    submit(m_exp + 1, done);
    check("miss_not_done", int'(done), 0);
    submit(m_exp, done);

    // Three misses force the advance; a later Go is ignored.
    new_eq(1);
    for (int w = 0; w < 3; w++) submit(wrong_answer(m_exp), done);
    check("forced_done", int'(done), 1);
    bus.Go = 1'b1;
    tick();
    bus.Go = 1'b0;
    tick();
    check("late_go_busy", int'(bus.Busy), 0);
    check("late_go_correct", int'(bus.Correct), 0);
    check("late_go_att", int'(bus.Attempts), 3);
    check("late_go_wrong", int'(bus.Wrong), 1);

    // Go held for 50 cycles counts as a single submission.
    new_eq(3);
    bus.DataIn = 7'(wrong_answer(m_exp));
    bus.Go = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("held_go_correct", int'(bus.Correct), 0);
    end
    check("held_go_att", int'(bus.Attempts), 1);
    check("held_go_busy", int'(bus.Busy), 1);
    bus.Go = 1'b0;
    m_att = 1;
    m_wrong = 1;
    tick();
    submit(m_exp, done);

    // Dropping Start in WAIT_GO aborts with operands held.
    new_eq(0);
    bus.Start = 1'b0;
    tick();
    check("abort_busy", int'(bus.Busy), 0);
    check("abort_correct", int'(bus.Correct), 0);
    check("abort_opa", int'(bus.OpA), m_a);
    check("abort_exp", int'(bus.Expected), m_exp);
    tick();
    check("abort_correct2", int'(bus.Correct), 0);

    // Reset during CHECK clears everything; Start held through reset restarts.
    new_eq(1);
    submit(wrong_answer(m_exp), done);
    bus.DataIn = 7'(m_exp);
    bus.Go = 1'b1;
    tick();
    bus.Go = 1'b0;
    #2 Reset = 1'b1;
    #1;
    check_all_zero("rst_check");
    @(negedge Clock);
    check("rst_hold_correct", int'(bus.Correct), 0);
    Reset = 1'b0;
    raise_start();
    submit(m_exp, done);

    // Randomized equations with a random number of misses before answering.
    for (int e = 0; e < 25; e++) begin
      int nwrong;
      new_eq(int'($urandom_range(0, 6)));
      nwrong = int'($urandom_range(0, 3));
      done = 1'b0;
      for (int w = 0; w < nwrong && !done; w++) submit(wrong_answer(m_exp), done);
      if (!done) submit(m_exp, done);
      check("rand_done", int'(done), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/equation_checker.md
EQUATION_CHECKER -- requirements
Module: equation_checker

Interface
REQ-001 The parameter list SHALL be, one per line: name, default, meaning.
- MAX_TRIES, 3, wrong attempts allowed before forced advance (1..3).
- LFSR_SEED, 8'hA5, LFSR reset value (SHALL be nonzero).

REQ-002 The port list SHALL be, one per line: name, direction, width, meaning.
- Clock, in, 1, system clock; all state updates on the rising edge.
- Reset, in, 1, asynchronous, active-high reset.
- Start, in, 1, level enable from the control FSM (startEqN); a rising edge begins one equation.
- Go, in, 1, answer-submit key, active-high level.
- DataIn, in, 7, player answer, unsigned.
- OpA, out, 4, displayed left operand.
- OpB, out, 4, displayed right operand.
- OpSel, out, 1, operator select: 0 = add, 1 = subtract.
- Expected, out, 7, correct result for the current equation.
- Correct, out, 1, one-cycle pulse meaning the equation is finished; the control FSM may advance.
- Wrong, out, 1, sticky flag: at least one wrong attempt since the last Start rising edge.
- Attempts, out, 2, wrong-attempt count.
- Busy, out, 1, high whenever state is not IDLE.

Function
REQ-003 The block SHALL register Start and Go once (Start_q, Go_q).
- StartRise = Start & ~Start_q.
- GoRise = Go & ~Go_q.

REQ-004 An 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL shift every clock from LFSR_SEED, independent of state.

REQ-005 The FSM SHALL have states IDLE, GEN, WAIT_GO, CHECK, RESULT; any unused encoding SHALL go to IDLE.

REQ-006 IDLE: on StartRise, go to GEN; in the same edge, clear Wrong and Attempts to 0.

REQ-007 GEN (one cycle), then go to WAIT_GO:
- OpSel <= lfsr[0].
- A = lfsr[7:4], B = lfsr[3:0].
- If OpSel = 1 and A < B, swap A and B so that OpA >= OpB.
- Latch OpA and OpB.
- Expected <= OpA + OpB (add) or OpA - OpB (subtract), zero-extended to 7 bits; range 0..30.

REQ-008 WAIT_GO: on GoRise, latch DataIn into an internal answer register and go to CHECK; a Go held high SHALL produce exactly one submission.

REQ-009 CHECK (one cycle):
- Answer == Expected: go to RESULT.
- Mismatch: Wrong <= 1 and Attempts <= Attempts + 1 (saturating at 3).
  - If the new count equals MAX_TRIES, go to RESULT (forced advance).
  - Otherwise, return to WAIT_GO.

REQ-010 RESULT: Correct = 1 for exactly this one cycle (Moore output), then go to IDLE.
- Wrong and Attempts SHALL hold their values until the next StartRise.

REQ-011 Start low in GEN, WAIT_GO or CHECK SHALL abort to IDLE on the next edge with no Correct pulse; OpA, OpB, Expected, Wrong and Attempts hold.

REQ-012 Start held high after RESULT SHALL NOT retrigger; a new equation needs a fresh StartRise.

REQ-013 A GoRise in any state other than WAIT_GO SHALL be ignored.

REQ-014 Latency:
- StartRise sampled at edge k: operands valid after edge k+1.
- GoRise sampled at edge m: CHECK after edge m, and a match gives Correct high during the cycle after edge m+1.

Reset
REQ-015 While Reset is high, the block SHALL hold:
- state = IDLE; LFSR = LFSR_SEED; Start_q = Go_q = 0.
- OpA, OpB, OpSel, Expected, Attempts = 0.
- Correct, Wrong, Busy = 0.

REQ-016 Reset asserted mid-operation SHALL return to IDLE immediately (asynchronously) with no Correct pulse.

REQ-017 After Reset deasserts, a Start already high SHALL count as a rising edge at the first clock.

Verification
REQ-018 Reset, then idle for 10 cycles with Start = 0 -> all outputs 0, Busy = 0, LFSR advancing.

REQ-019 Start 0->1, read Expected, drive DataIn = Expected, pulse Go for 1 cycle -> Correct high exactly 1 cycle, two cycles after the GoRise edge; Wrong = 0; Attempts = 0; Busy then 0.

REQ-020 DataIn = Expected+1 with Go, then DataIn = Expected with Go -> after the first submission Wrong = 1, Attempts = 1, no Correct; after the second a Correct pulse, with Wrong still 1.

REQ-021 Three wrong submissions with MAX_TRIES = 3 -> Attempts = 3, Wrong = 1, Correct pulse after the third CHECK; a fourth Go is ignored.

REQ-022 Go held high for 50 cycles in WAIT_GO with a wrong answer -> exactly one submission, Attempts = 1.

REQ-023 Drop Start in WAIT_GO, or assert Reset in CHECK -> IDLE with no Correct pulse; Reset additionally clears Wrong, Attempts and OpA.
